// File: rtl/life_pkg.sv
// Shared definitions for the generation-grid scanner.
// Optional feature macro: SCAN_BLANK_EN (adds the BLANK state between rows).
package life_pkg;

  localparam int GRID_W = 16;   // cells per row
  localparam int GRID_N = 256;  // cells per grid
  localparam int ROWS   = 16;   // rows per grid

  // Scan controller states; BLANK is only present when blanking is built in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1
`ifdef SCAN_BLANK_EN
    ,
    ST_BLANK = 2'd2
`endif
  } scan_state_e;

endpackage

// File: rtl/row_mux.sv
// Combinational row selector: picks row sel out of a 256-bit grid,
// row r living at grid[255-16r -: 16].
module row_mux
  import life_pkg::*;
(
  input  logic [GRID_N-1:0] grid,
  input  logic [3:0]        sel,
  output logic [GRID_W-1:0] row
);

  // Constant-index select per row keeps every part-select static.
  always_comb begin
    row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (sel == 4'(r)) row = grid[GRID_N-1-GRID_W*r -: GRID_W];
    end
  end

endmodule

// File: rtl/gen_scan.sv
// Generation-grid row scanner with a double buffer (shadow/active).
// Optional feature macro: SCAN_BLANK_EN inserts BLANK_CYC row_en-low
// cycles after every row dwell.
//
// Handshake: gin is taken into shadow on any rising edge where
// gin_valid && gin_ready. gin_ready is !shadow_full, so it drops the cycle
// after a transfer and rises the cycle after shadow is swapped into active.
// The producer may raise or drop gin_valid at any time.
module gen_scan
  import life_pkg::*;
#(
  parameter int DWELL     = 4,  // cycles each row is driven, 1..255
  parameter int BLANK_CYC = 2   // blank cycles between rows (SCAN_BLANK_EN only)
)
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [GRID_N-1:0] gin,
  input  logic              gin_valid,
  output logic              gin_ready,
  output logic [GRID_W-1:0] row_data,
  output logic [3:0]        row_sel,
  output logic              row_en,
  output logic              frame_done,
  output logic              busy,
  output scan_state_e       dbg_state
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);

  scan_state_e       state, state_d;
  logic [7:0]        cnt, cnt_d;
  logic [3:0]        row_sel_d;
  logic [GRID_N-1:0] active, active_d;
  logic [GRID_N-1:0] shadow, shadow_d;
  logic              shadow_full, full_d;
  logic              frame_done_d;
  logic              xfer;
  logic              step;
  logic              in_blank;
  logic              cnt_end;

  assign xfer = gin_valid && gin_ready;

`ifdef SCAN_BLANK_EN
  assign in_blank = (state == ST_BLANK);
`else
  assign in_blank = 1'b0;
`endif

  // One counter serves both the dwell and the blank interval.
  assign cnt_end = (cnt == (in_blank ? BLANK_LAST : DWELL_LAST));

  // State and datapath registers; reset aborts the scan and empties both buffers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      row_sel     <= '0;
      active      <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      row_sel     <= row_sel_d;
      active      <= active_d;
      shadow      <= shadow_d;
      shadow_full <= full_d;
      frame_done  <= frame_done_d;
    end
  end

  // Next-state logic: capture, start-up swap, dwell/blank counting, row stepping.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    row_sel_d    = row_sel;
    active_d     = active;
    shadow_d     = shadow;
    full_d       = shadow_full;
    frame_done_d = 1'b0;
    step         = 1'b0;

    if (xfer) begin
      shadow_d = gin;
      full_d   = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (shadow_full) begin
          active_d  = shadow;
          full_d    = 1'b0;
          row_sel_d = '0;
          cnt_d     = '0;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cnt_end) begin
          cnt_d        = '0;
          frame_done_d = (row_sel == 4'd15);
`ifdef SCAN_BLANK_EN
          state_d      = ST_BLANK;
`else
          step         = 1'b1;
`endif
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
`ifdef SCAN_BLANK_EN
      ST_BLANK: begin
        if (cnt_end) begin
          cnt_d   = '0;
          state_d = ST_SCAN;
          step    = 1'b1;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Advance to the next row; at the frame wrap take a waiting grid if any.
    // A transfer cannot coincide with this swap because gin_ready is low
    // whenever shadow is full.
    if (step) begin
      if (row_sel == 4'd15) begin
        row_sel_d = '0;
        if (shadow_full) begin
          active_d = shadow;
          full_d   = 1'b0;
        end
      end else begin
        row_sel_d = row_sel + 4'd1;
      end
    end
  end

  row_mux u_row_mux (
    .grid (active),
    .sel  (row_sel),
    .row  (row_data)
  );

  // Status outputs decoded straight from the registers.
  always_comb begin
    row_en    = (state == ST_SCAN);
    busy      = (state != ST_IDLE);
    gin_ready = !shadow_full;
    dbg_state = state;
  end

endmodule
